metronomo_beat_gen: RTL and testbench

- Upstream stage of the metronome LED rotator: produces the one-cycle beat enable that advances the alternating LEDs.
- Holds the current BPM value, exported for the BPM display.
- Adjusts BPM from two raw push-buttons (up/down) through synchroniser, debounce and edge-detect logic.
- Beat timing uses a phase accumulator, so the average beat period is exact for any BPM with no divider.

---
 rtl/metronomo_pkg.sv | 24 ++
 rtl/metronomo_beat_gen_btn_debounce.sv | 65 ++++++
 rtl/metronomo_beat_gen.sv | 108 ++++++++++
 tb/tb_metronomo_beat_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/metronomo_pkg.sv
// Shared types, default BPM bounds and constant helpers for the metronome beat generator.
//   bpm_t      : 8-bit unsigned BPM value
//   beat_limit : accumulator wrap value, clk_hz * 60 (one beat = LIMIT units of bpm per cycle)
//   acc_width  : accumulator width able to hold LIMIT + bpm_max without overflow
package metronomo_pkg;

  localparam int unsigned BPM_W = 8;

  typedef logic [BPM_W-1:0] bpm_t;

  localparam int unsigned DEF_BPM_MIN     = 30;
  localparam int unsigned DEF_BPM_DEFAULT = 60;
  localparam int unsigned DEF_BPM_MAX     = 240;

  function automatic longint unsigned beat_limit(input longint unsigned clk_hz);
    return clk_hz * 64'd60;
  endfunction

  function automatic int unsigned acc_width(input longint unsigned clk_hz,
                                            input longint unsigned bpm_max);
    return 32'($clog2(beat_limit(clk_hz) + bpm_max + 64'd1));
  endfunction

endpackage

// File: rtl/metronomo_beat_gen_btn_debounce.sv
// Push-button conditioner: polarity normalise, 2-FF synchroniser, debounce, press edge detect.
//   clk, rst_n     : clock, async active-low reset
//   btn_raw        : asynchronous raw button
//   pressed_pulse  : registered one-cycle pulse on an accepted press (never on release)
//   level          : debounced button state, 1 = pressed
module btn_debounce #(
  parameter int unsigned DB_CYCLES  = 500_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pressed_pulse,
  output logic level
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             btn_norm;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             pulse_q, pulse_d;

  assign btn_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Counter runs only while the synchronised level disagrees with the accepted state;
  // any return to agreement restarts the window, so short bounces are discarded.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    pulse_d  = stable_q & ~stable_dly_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_norm;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      pulse_q      <= pulse_d;
    end
  end

  assign pressed_pulse = pulse_q;
  assign level         = stable_q;

endmodule

// File: rtl/metronomo_beat_gen.sv
// Metronome beat generator: BPM register adjusted by up/down buttons and a phase
// accumulator producing an exact-average beat strobe.
//   clk, rst_n    : clock, async active-low reset
//   btn_up_raw    : raw up button (asynchronous)
//   btn_down_raw  : raw down button (asynchronous)
//   beat_tick     : registered one-cycle beat strobe for the LED rotator
//   bpm           : current BPM for the display
module metronomo_beat_gen
  import metronomo_pkg::*;
#(
  parameter longint unsigned CLK_HZ         = 64'd50_000_000,
  parameter int unsigned     BPM_DEFAULT    = DEF_BPM_DEFAULT,
  parameter int unsigned     BPM_MIN        = DEF_BPM_MIN,
  parameter int unsigned     BPM_MAX        = DEF_BPM_MAX,
  parameter int unsigned     BPM_STEP       = 1,
  parameter int unsigned     DB_CYCLES      = 500_000,
  parameter bit              BTN_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up_raw,
  input  logic             btn_down_raw,
  output logic             beat_tick,
  output logic [BPM_W-1:0] bpm
);

  localparam longint unsigned LIMIT  = beat_limit(CLK_HZ);
  localparam int unsigned     ACC_W  = acc_width(CLK_HZ, 64'(BPM_MAX));
  localparam int unsigned     BPMX_W = BPM_W + 1;

  localparam logic [ACC_W-1:0]  LIMIT_W = ACC_W'(LIMIT);
  localparam logic [BPMX_W-1:0] STEP_X  = BPMX_W'(BPM_STEP);
  localparam logic [BPMX_W-1:0] MIN_X   = BPMX_W'(BPM_MIN);
  localparam logic [BPMX_W-1:0] MAX_X   = BPMX_W'(BPM_MAX);

  if (!(BPM_MIN <= BPM_DEFAULT && BPM_DEFAULT <= BPM_MAX && BPM_MAX <= 255 &&
        BPM_STEP >= 1 && BPM_STEP <= 255 && DB_CYCLES >= 2)) begin : g_param_check
    $error("metronomo_beat_gen: illegal BPM/debounce parameters");
  end

  bpm_t              bpm_q, bpm_d;
  logic [ACC_W-1:0]  acc_q, acc_d, sum;
  logic              tick_q, tick_d;
  logic [BPMX_W-1:0] bpm_x, up_sum, dn_diff;
  logic              up_pulse, dn_pulse;
  logic              up_level, dn_level;
  logic              levels_unused;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_up (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_up_raw),
    .pressed_pulse (up_pulse),
    .level         (up_level)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_dn (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_down_raw),
    .pressed_pulse (dn_pulse),
    .level         (dn_level)
  );

  // Debounced levels are not needed here; presses are consumed as pulses only.
  assign levels_unused = up_level ^ dn_level;

  // BPM saturating update (one bit wider to catch over/underflow) and beat accumulator.
  always_comb begin
    bpm_d   = bpm_q;
    acc_d   = acc_q;
    tick_d  = 1'b0;
    bpm_x   = {1'b0, bpm_q};
    up_sum  = bpm_x + STEP_X;
    dn_diff = bpm_x - STEP_X;
    sum     = acc_q + ACC_W'(bpm_q);

    if (up_pulse && !dn_pulse) begin
      bpm_d = (up_sum > MAX_X) ? BPM_W'(BPM_MAX) : BPM_W'(up_sum);
    end else if (dn_pulse && !up_pulse) begin
      bpm_d = ((STEP_X > bpm_x) || (dn_diff < MIN_X)) ? BPM_W'(BPM_MIN) : BPM_W'(dn_diff);
    end

    // Carry the remainder past LIMIT so fractional periods average out exactly.
    if (sum >= LIMIT_W) begin
      acc_d  = sum - LIMIT_W;
      tick_d = 1'b1;
    end else begin
      acc_d  = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpm_q  <= BPM_W'(BPM_DEFAULT);
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      bpm_q  <= bpm_d;
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign beat_tick = tick_q;
  assign bpm       = bpm_q;

endmodule

// File: tb/tb_metronomo_beat_gen.sv
// Self-checking bench for metronomo_beat_gen (CLK_HZ=1000, DB_CYCLES=4, active-high buttons).
// Reference model: beats counted as floor(total bpm-cycles / LIMIT); a button is accepted
// once its synchronised samples have disagreed with the accepted state DB times in a row.
module tb_metronomo_beat_gen;

  localparam longint unsigned CLK_HZ = 64'd1000;
  localparam int unsigned     DB     = 4;
  localparam longint          LIMIT  = 60000;
  localparam int              B_MIN  = 30;
  localparam int              B_MAX  = 240;
  localparam int              B_DEF  = 60;

  bit         clk = 1'b0;
  bit         rst_n = 1'b0;
  bit         up_raw = 1'b0;
  bit         dn_raw = 1'b0;
  logic       beat_tick;
  logic [7:0] bpm;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  metronomo_beat_gen #(
    .CLK_HZ         (CLK_HZ),
    .BPM_DEFAULT    (60),
    .BPM_MIN        (30),
    .BPM_MAX        (240),
    .BPM_STEP       (1),
    .DB_CYCLES      (DB),
    .BTN_ACTIVE_LOW (1'b0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_up_raw   (up_raw),
    .btn_down_raw (dn_raw),
    .beat_tick    (beat_tick),
    .bpm          (bpm)
  );

  // ---------------- reference model ----------------
  int     m_bpm;
  bit     m_tick;
  longint m_total, m_beats;
  bit     hq_up[$], hq_dn[$];
  bit     m_st_up, m_st_dn, m_rise_up, m_rise_dn, m_pls_up, m_pls_dn;

  function automatic void model_reset();
    m_bpm = B_DEF; m_tick = 0; m_total = 0; m_beats = 0;
    m_st_up = 0; m_st_dn = 0; m_rise_up = 0; m_rise_dn = 0; m_pls_up = 0; m_pls_dn = 0;
    hq_up.delete(); hq_dn.delete();
    for (int i = 0; i < int'(DB) + 2; i++) begin
      hq_up.push_back(1'b0);
      hq_dn.push_back(1'b0);
    end
  endfunction

  // Newest sample at index 0; the debouncer sees samples two cycles old.
  function automatic bit accepted(input bit q[$], input bit st);
    bit all_diff = 1'b1;
    for (int j = 2; j < int'(DB) + 2; j++) if (q[j] == st) all_diff = 1'b0;
    return all_diff;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_total = m_total + m_bpm;
      m_tick  = (m_total / LIMIT) != m_beats;
      m_beats = m_total / LIMIT;
      if (m_pls_up && !m_pls_dn)      m_bpm = (m_bpm + 1 > B_MAX) ? B_MAX : m_bpm + 1;
      else if (m_pls_dn && !m_pls_up) m_bpm = (m_bpm - 1 < B_MIN) ? B_MIN : m_bpm - 1;
      m_pls_up = m_rise_up;
      m_pls_dn = m_rise_dn;
      hq_up.push_front(up_raw); void'(hq_up.pop_back());
      hq_dn.push_front(dn_raw); void'(hq_dn.pop_back());
      m_rise_up = 1'b0;
      m_rise_dn = 1'b0;
      if (accepted(hq_up, m_st_up)) begin m_rise_up = !m_st_up; m_st_up = !m_st_up; end
      if (accepted(hq_dn, m_st_dn)) begin m_rise_dn = !m_st_dn; m_st_dn = !m_st_dn; end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("tick_vs_model", 32'(beat_tick), 32'(m_tick));
    chk("bpm_vs_model", 32'(bpm), 32'(m_bpm));
  endtask

  task automatic press(input bit u, input bit d, input int hold, input int gap);
    up_raw = u; dn_raw = d;
    repeat (hold) step();
    up_raw = 1'b0; dn_raw = 1'b0;
    repeat (gap) step();
  endtask

  // Steps until beat_tick; returns edge count, or 0 if no tick within the budget.
  task automatic wait_tick(output int edges);
    bit found = 1'b0;
    edges = 0;
    for (int i = 1; i <= 1100 && !found; i++) begin
      step();
      if (beat_tick === 1'b1) begin edges = i; found = 1'b1; end
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({tag, "_tick"}, 32'(beat_tick), 32'd0);
    chk({tag, "_bpm"}, 32'(bpm), 32'd60);
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    int e;
    model_reset();
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_bpm", 32'(bpm), 32'd60);
    chk("reset_tick", 32'(beat_tick), 32'd0);
    rst_n = 1'b1;

    // Beat timing at 60 BPM: first tick at edge 1000, then every 1000 cycles.
    wait_tick(e);
    chk("first_tick_edge", 32'(e), 32'd1000);
    wait_tick(e);
    chk("beat_period", 32'(e), 32'd1000);
    repeat (700) step();
    do_reset("midop_rst");
    wait_tick(e);
    chk("tick_after_rst", 32'(e), 32'd1000);

    // Press latency: pulse 7 cycles after press, bpm updated on the next.
    up_raw = 1'b1;
    repeat (7) step();
    chk("lat_before", 32'(bpm), 32'd60);
    step();
    chk("lat_after", 32'(bpm), 32'd61);
    repeat (40) step();
    chk("held_no_repeat", 32'(bpm), 32'd61);
    up_raw = 1'b0;
    repeat (12) step();
    press(1'b0, 1'b1, 20, 12);
    chk("down_press", 32'(bpm), 32'd60);

    // Bounce: 2-cycle toggling is rejected, the final held level counts once.
    for (int i = 0; i < 30; i++) begin
      up_raw = ((i / 2) % 2) == 0;
      step();
    end
    chk("bounce_rejected", 32'(bpm), 32'd60);
    up_raw = 1'b1;
    repeat (20) step();
    chk("bounce_one_inc", 32'(bpm), 32'd61);
    up_raw = 1'b0;
    repeat (12) step();

    // Saturation at both bounds.
    repeat (239 - 61) press(1'b1, 1'b0, 6, 8);
    chk("reach_239", 32'(bpm), 32'd239);
    for (int k = 0; k < 3; k++) begin
      press(1'b1, 1'b0, 6, 8);
      chk("sat_max", 32'(bpm), 32'd240);
    end
    repeat (240 - 31) press(1'b0, 1'b1, 6, 8);
    chk("reach_31", 32'(bpm), 32'd31);
    for (int k = 0; k < 3; k++) begin
      press(1'b0, 1'b1, 6, 8);
      chk("sat_min", 32'(bpm), 32'd30);
    end

    // Simultaneous presses cancel.
    press(1'b1, 1'b0, 6, 8);
    chk("pre_both", 32'(bpm), 32'd31);
    press(1'b1, 1'b1, 20, 12);
    chk("both_no_change", 32'(bpm), 32'd31);

    // Random button activity against the model.
    for (int s = 0; s < 400; s++) begin
      up_raw = 1'($urandom_range(0, 1));
      dn_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) step();
    end
    up_raw = 1'b0; dn_raw = 1'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
